// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle for pipe_stage: the upstream (in_*) and downstream (out_*) sides.
// slave is the stage's view, master is the view of the logic driving the stage.
interface pipe_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage.sv
// Reusable pipeline stage register with valid/ready handshake, flush and saturating event counters.
// Define PIPE_STAGE_SKID_EN to add the skid register S and a registered in_ready.
module pipe_stage #(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_if.slave      bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              r_m_vld;
    logic [DATA_W-1:0] r_m_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_in_rdy;
    logic              w_in_xfer;
    logic              w_out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_s_vld;
    logic [DATA_W-1:0] r_s_data;

    // S being empty is the only acceptance condition, so in_ready never sees out_ready.
    assign w_in_rdy  = ~r_s_vld;
    assign occupancy = {r_m_vld & r_s_vld, r_m_vld ^ r_s_vld};
`else
    assign w_in_rdy  = ~r_m_vld | bus.out_ready;
    assign occupancy = {1'b0, r_m_vld};
`endif

    assign w_in_xfer     = bus.in_valid & w_in_rdy;
    assign w_out_xfer    = r_m_vld & bus.out_ready;
    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_m_vld;
    assign bus.out_data  = r_m_data;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_vld  <= 1'b0;
            r_m_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
            r_s_vld  <= 1'b0;
            r_s_data <= '0;
`endif
        end else if (flush) begin
            r_m_vld <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            r_s_vld <= 1'b0;
            if (CLEAR_ON_FLUSH != 0) r_s_data <= '0;
`endif
            if (CLEAR_ON_FLUSH != 0) r_m_data <= '0;
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            // A draining S blocks input that cycle, so the S->M move never races a new beat.
            if (w_out_xfer && r_s_vld) begin
                r_m_data <= r_s_data;
                r_s_vld  <= 1'b0;
            end else if (w_in_xfer && r_m_vld && !bus.out_ready) begin
                r_s_data <= bus.in_data;
                r_s_vld  <= 1'b1;
            end else if (w_in_xfer) begin
                r_m_data <= bus.in_data;
                r_m_vld  <= 1'b1;
            end else if (w_out_xfer) begin
                r_m_vld <= 1'b0;
            end
`else
            if (w_in_xfer) begin
                r_m_data <= bus.in_data;
                r_m_vld  <= 1'b1;
            end else if (w_out_xfer) begin
                r_m_vld <= 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_m_vld && !bus.out_ready && !flush) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (flush && (occupancy != 2'd0))        r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

endmodule
